// File: rtl/jtag_host_master.sv
// Host-side JTAG initiator: bit-bangs a TAP through one IR write ({1,wr,rd})
// and one DR exchange, returning the word shifted out of TDO.
module jtag_host_master #(
  parameter int CLK_DIV = 2,
  parameter int DR_LEN  = 32,
  parameter int IR_LEN  = 9
) (
  input  logic              iCLK,
  input  logic              iRST,
  input  logic              iSTART,
  input  logic [3:0]        iWR_ADDR,
  input  logic [3:0]        iRD_ADDR,
  input  logic [DR_LEN-1:0] iWDATA,
  output logic              oBUSY,
  output logic              oDONE,
  output logic [DR_LEN-1:0] oRDATA,
  output logic              oTCK,
  output logic              oTMS,
  output logic              oTDI,
  input  logic              iTDO
);
  localparam int MAX_LEN = (IR_LEN > DR_LEN) ? IR_LEN : DR_LEN;
  localparam int CNT_W   = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int PAD_W   = 1 << CNT_W;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  // Encoded in sequence order so the next phase is always state + 1.
  localparam logic [3:0] S_IDLE     = 4'd0;
  localparam logic [3:0] S_TLR      = 4'd1;
  localparam logic [3:0] S_IR_HDR   = 4'd2;
  localparam logic [3:0] S_IR_SHIFT = 4'd3;
  localparam logic [3:0] S_IR_TAIL  = 4'd4;
  localparam logic [3:0] S_DR_HDR   = 4'd5;
  localparam logic [3:0] S_DR_SHIFT = 4'd6;
  localparam logic [3:0] S_DR_TAIL  = 4'd7;
  localparam logic [3:0] S_DONE     = 4'd8;

  logic [3:0]        state_q, state_d, ns;
  logic [CNT_W-1:0]  cnt_q, cnt_d, nc;
  logic [DIV_W-1:0]  div_q, div_d;
  logic              tck_q, tck_d, tms_q, tms_d, tdi_q, tdi_d;
  logic              busy_q, busy_d, done_q, done_d, unk_q, unk_d;
  logic [PAD_W-1:0]  ir_q, ir_d, wd_q, wd_d, cap_q, cap_d;
  logic [DR_LEN-1:0] rdata_q, rdata_d;
  logic              eop, last;

  function automatic logic [CNT_W-1:0] last_bit(input logic [3:0] s);
    case (s)
      S_TLR:      last_bit = CNT_W'(5);
      S_IR_HDR:   last_bit = CNT_W'(3);
      S_IR_SHIFT: last_bit = CNT_W'(IR_LEN - 1);
      S_DR_HDR:   last_bit = CNT_W'(2);
      S_DR_SHIFT: last_bit = CNT_W'(DR_LEN - 1);
      default:    last_bit = CNT_W'(1);
    endcase
  endfunction

  function automatic logic tms_of(input logic [3:0] s, input logic [CNT_W-1:0] c);
    case (s)
      S_TLR:                         tms_of = (c != last_bit(s));
      S_IR_HDR:                      tms_of = (c < CNT_W'(2));
      S_IR_SHIFT, S_DR_SHIFT:        tms_of = (c == last_bit(s));
      S_IR_TAIL, S_DR_HDR, S_DR_TAIL: tms_of = (c == '0);
      default:                       tms_of = 1'b0;
    endcase
  endfunction

  always_comb begin
    state_d = state_q; cnt_d = cnt_q; div_d = div_q;
    tck_d = tck_q; tms_d = tms_q; tdi_d = tdi_q;
    busy_d = busy_q; done_d = 1'b0; unk_d = unk_q;
    ir_d = ir_q; wd_d = wd_q; cap_d = cap_q; rdata_d = rdata_q;
    eop  = (div_q == DIV_W'(CLK_DIV - 1));
    last = (cnt_q == last_bit(state_q));
    ns   = last ? state_q + 4'd1 : state_q;
    nc   = last ? '0 : cnt_q + CNT_W'(1);
    case (state_q)
      S_IDLE: begin
        tck_d = 1'b0;
        if (iSTART) begin
          state_d = unk_q ? S_TLR : S_IR_HDR;
          cnt_d   = '0;
          div_d   = '0;
          busy_d  = 1'b1;
          tms_d   = 1'b1;  // both TLR and IR_HDR open with TMS=1
          tdi_d   = 1'b0;
          ir_d    = PAD_W'({1'b1, iWR_ADDR, iRD_ADDR});
          wd_d    = PAD_W'(iWDATA);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        tck_d   = 1'b0;
        div_d   = '0;
      end
      default: begin
        div_d = eop ? '0 : div_q + DIV_W'(1);
        if (eop) tck_d = ~tck_q;
        if (eop && !tck_q && state_q == S_DR_SHIFT) cap_d[cnt_q] = iTDO;
        if (eop && tck_q) begin
          state_d = ns;
          cnt_d   = nc;
          tms_d   = tms_of(ns, nc);
          tdi_d   = (ns == S_IR_SHIFT) ? ir_q[nc] :
                    (ns == S_DR_SHIFT) ? wd_q[nc] : 1'b0;
          if (state_q == S_TLR && last) unk_d = 1'b0;
        end
        // The final high-phase cycle of the last TCK doubles as the DONE cycle.
        if (state_q == S_DR_TAIL && last && tck_d && div_d == DIV_W'(CLK_DIV - 1)) begin
          state_d = S_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          rdata_d = cap_q[DR_LEN-1:0];
        end
      end
    endcase
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state_q <= S_IDLE; cnt_q <= '0; div_q <= '0;
      tck_q <= 1'b0; tms_q <= 1'b1; tdi_q <= 1'b0;
      busy_q <= 1'b0; done_q <= 1'b0; unk_q <= 1'b1;
      ir_q <= '0; wd_q <= '0; cap_q <= '0; rdata_q <= '0;
    end else begin
      state_q <= state_d; cnt_q <= cnt_d; div_q <= div_d;
      tck_q <= tck_d; tms_q <= tms_d; tdi_q <= tdi_d;
      busy_q <= busy_d; done_q <= done_d; unk_q <= unk_d;
      ir_q <= ir_d; wd_q <= wd_d; cap_q <= cap_d; rdata_q <= rdata_d;
    end
  end

  assign oBUSY  = busy_q;
  assign oDONE  = done_q;
  assign oRDATA = rdata_q;
  assign oTCK   = tck_q;
  assign oTMS   = tms_q;
  assign oTDI   = tdi_q;
endmodule

// File: tb/tb_jtag_host_master.sv
// Directed bench for jtag_host_master: TAP + register-file target model,
// one DUT at CLK_DIV=2 and one at CLK_DIV=1 sharing the model via a select.
module tb_jtag_host_master;
  logic        iCLK = 1'b0, iRST = 1'b1;
  logic        start0 = 1'b0, start1 = 1'b0;
  logic [3:0]  wr_a = 4'hF, rd_a = 4'hF;
  logic [31:0] wdata = '0;
  logic        iTDO = 1'b0;
  logic        busy0, done0, tck0, tms0, tdi0;
  logic        busy1, done1, tck1, tms1, tdi1;
  logic [31:0] rdata0, rdata1;
  logic        sel = 1'b0;
  logic        tck_m, tms_m, tdi_m, done_m;
  int          compared = 0, mismatched = 0;
  int          cyc = 0;

  always #5 iCLK = ~iCLK;
  always @(posedge iCLK) cyc <= cyc + 1;

  jtag_host_master #(.CLK_DIV(2), .DR_LEN(32), .IR_LEN(9)) dut0 (
    .iCLK(iCLK), .iRST(iRST), .iSTART(start0), .iWR_ADDR(wr_a), .iRD_ADDR(rd_a),
    .iWDATA(wdata), .oBUSY(busy0), .oDONE(done0), .oRDATA(rdata0),
    .oTCK(tck0), .oTMS(tms0), .oTDI(tdi0), .iTDO(iTDO));

  jtag_host_master #(.CLK_DIV(1), .DR_LEN(32), .IR_LEN(9)) dut1 (
    .iCLK(iCLK), .iRST(iRST), .iSTART(start1), .iWR_ADDR(wr_a), .iRD_ADDR(rd_a),
    .iWDATA(wdata), .oBUSY(busy1), .oDONE(done1), .oRDATA(rdata1),
    .oTCK(tck1), .oTMS(tms1), .oTDI(tdi1), .iTDO(iTDO));

  assign tck_m  = sel ? tck1 : tck0;
  assign tms_m  = sel ? tms1 : tms0;
  assign tdi_m  = sel ? tdi1 : tdi0;
  assign done_m = sel ? done1 : done0;

  // Target TAP controller states
  localparam logic [3:0] T_TLR = 4'd0, T_RTI = 4'd1, T_SELDR = 4'd2, T_CAPDR = 4'd3,
    T_SHDR = 4'd4, T_EX1DR = 4'd5, T_PDR = 4'd6, T_EX2DR = 4'd7, T_UPDR = 4'd8,
    T_SELIR = 4'd9, T_CAPIR = 4'd10, T_SHIR = 4'd11, T_EX1IR = 4'd12, T_PIR = 4'd13,
    T_EX2IR = 4'd14, T_UPIR = 4'd15;

  function automatic logic [3:0] tap_next(input logic [3:0] s, input logic tms);
    case (s)
      T_TLR:   tap_next = tms ? T_TLR   : T_RTI;
      T_RTI:   tap_next = tms ? T_SELDR : T_RTI;
      T_SELDR: tap_next = tms ? T_SELIR : T_CAPDR;
      T_CAPDR: tap_next = tms ? T_EX1DR : T_SHDR;
      T_SHDR:  tap_next = tms ? T_EX1DR : T_SHDR;
      T_EX1DR: tap_next = tms ? T_UPDR  : T_PDR;
      T_PDR:   tap_next = tms ? T_EX2DR : T_PDR;
      T_EX2DR: tap_next = tms ? T_UPDR  : T_SHDR;
      T_UPDR:  tap_next = tms ? T_SELDR : T_RTI;
      T_SELIR: tap_next = tms ? T_TLR   : T_CAPIR;
      T_CAPIR: tap_next = tms ? T_EX1IR : T_SHIR;
      T_SHIR:  tap_next = tms ? T_EX1IR : T_SHIR;
      T_EX1IR: tap_next = tms ? T_UPIR  : T_PIR;
      T_PIR:   tap_next = tms ? T_EX2IR : T_PIR;
      T_EX2IR: tap_next = tms ? T_UPIR  : T_SHIR;
      default: tap_next = tms ? T_SELDR : T_RTI;
    endcase
  endfunction

  logic [3:0]  tap_st = T_SHDR;   // power-up state deliberately not TLR
  logic [8:0]  ir_sh = '0, ir_cur = 9'h1FF, ir_last = '0;
  logic [31:0] dr_sh = '0, dr_last = '0;
  logic [31:0] mem [16] = '{default: '0};
  logic [63:0] tms_hist = '0;
  int          tck_cnt = 0;

  always @(posedge tck_m) begin
    tck_cnt  <= tck_cnt + 1;
    tms_hist <= {tms_hist[62:0], tms_m};
    case (tap_st)
      T_SHIR:  ir_sh <= {tdi_m, ir_sh[8:1]};
      T_UPIR:  begin ir_cur <= ir_sh; ir_last <= ir_sh; end
      T_CAPDR: dr_sh <= (ir_cur[3:0] == 4'hF) ? 32'h0 : mem[ir_cur[3:0]];
      T_SHDR:  dr_sh <= {tdi_m, dr_sh[31:1]};
      T_UPDR:  begin
        dr_last <= dr_sh;
        if (ir_cur[7:4] != 4'hF) mem[ir_cur[7:4]] <= dr_sh;
      end
      default: ;
    endcase
    tap_st <= tap_next(tap_st, tms_m);
  end

  always @(negedge tck_m) iTDO <= dr_sh[0];

  // CLK_DIV=1 toggle monitor
  logic prev_tck1 = 1'b0, prev_busy1 = 1'b0;
  int   tgl_n = 0, tgl_bad = 0;
  always @(negedge iCLK) begin
    if (busy1 && prev_busy1) begin
      tgl_n <= tgl_n + 1;
      if (tck1 == prev_tck1) tgl_bad <= tgl_bad + 1;
    end
    prev_tck1  <= tck1;
    prev_busy1 <= busy1;
  end

  function automatic logic [63:0] push(input logic [63:0] e, input logic b, input int n);
    logic [63:0] r = e;
    for (int i = 0; i < n; i++) r = {r[62:0], b};
    return r;
  endfunction

  // Expected TMS trace, newest bit at LSB
  function automatic logic [63:0] exp_tms(input bit tlr);
    logic [63:0] e = '0;
    if (tlr) begin e = push(e, 1'b1, 5); e = push(e, 1'b0, 1); end
    e = push(e, 1'b1, 2); e = push(e, 1'b0, 2);
    e = push(e, 1'b0, 8); e = push(e, 1'b1, 1);
    e = push(e, 1'b1, 1); e = push(e, 1'b0, 1);
    e = push(e, 1'b1, 1); e = push(e, 1'b0, 2);
    e = push(e, 1'b0, 31); e = push(e, 1'b1, 1);
    e = push(e, 1'b1, 1); e = push(e, 1'b0, 1);
    return e;
  endfunction

  function automatic logic [63:0] hist(input int n);
    logic [63:0] m = (64'd1 << n) - 64'd1;
    return tms_hist & m;
  endfunction

  task automatic run_txn(input bit which, input logic [3:0] wr, input logic [3:0] rd,
                         input logic [31:0] wd, input bit spam,
                         output int lat, output int ntck, output int ndone);
    int a, t0, post;
    @(negedge iCLK);
    sel = which; wr_a = wr; rd_a = rd; wdata = wd;
    if (which) start1 = 1'b1; else start0 = 1'b1;
    a = cyc; t0 = tck_cnt; lat = -1; ndone = 0; post = 0;
    for (int k = 0; k < 1200 && post < 40; k++) begin
      @(negedge iCLK);
      if (done_m) begin
        ndone++;
        if (lat < 0) lat = cyc - a;
      end
      if (lat >= 0) post++;
      if (spam && lat < 0) begin
        wr_a = 4'h6; rd_a = 4'h2; wdata = 32'hFFFF0000 ^ 32'(k);
      end else begin
        start0 = 1'b0; start1 = 1'b0;
      end
    end
    start0 = 1'b0; start1 = 1'b0;
    ntck = tck_cnt - t0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge iCLK);
    compared++;
    if ({tck0, tms0, tdi0, busy0, done0} !== 5'b01000) begin
      mismatched++; $display("FAIL reset_pins0: got %b want 01000", {tck0, tms0, tdi0, busy0, done0});
    end
    compared++;
    if ({tck1, tms1, tdi1, busy1, done1} !== 5'b01000) begin
      mismatched++; $display("FAIL reset_pins1: got %b want 01000", {tck1, tms1, tdi1, busy1, done1});
    end
    iRST = 1'b0;
    repeat (3) @(negedge iCLK);
    compared++;
    if ({tck0, tms0, tdi0, busy0, done0} !== 5'b01000) begin
      mismatched++; $display("FAIL idle_pins0: got %b want 01000", {tck0, tms0, tdi0, busy0, done0});
    end
    compared++;
    if (rdata0 !== 32'h0 || rdata1 !== 32'h0) begin
      mismatched++; $display("FAIL reset_rdata: got %h/%h want 0", rdata0, rdata1);
    end
  endtask

  task automatic test_first_write();
    int lat, ntck, nd;
    run_txn(1'b0, 4'h3, 4'hF, 32'hDEADBEEF, 1'b0, lat, ntck, nd);
    compared++;
    if (ntck !== 58) begin mismatched++; $display("FAIL t1_tck: got %0d want 58", ntck); end
    compared++;
    if (ir_last !== 9'b1_0011_1111) begin mismatched++; $display("FAIL t1_ir: got %b want 100111111", ir_last); end
    compared++;
    if (dr_last !== 32'hDEADBEEF) begin mismatched++; $display("FAIL t1_dr: got %h want deadbeef", dr_last); end
    compared++;
    if (rdata0 !== 32'h0) begin mismatched++; $display("FAIL t1_rdata: got %h want 0", rdata0); end
    compared++;
    if (lat !== 232) begin mismatched++; $display("FAIL t1_latency: got %0d want 232", lat); end
    compared++;
    if (hist(58) !== exp_tms(1'b1)) begin mismatched++; $display("FAIL t1_tms: got %h want %h", hist(58), exp_tms(1'b1)); end
    compared++;
    if (nd !== 1) begin mismatched++; $display("FAIL t1_done_count: got %0d want 1", nd); end
  endtask

  task automatic test_read_back();
    int lat, ntck, nd;
    run_txn(1'b0, 4'hF, 4'h3, 32'h0BADF00D, 1'b0, lat, ntck, nd);
    compared++;
    if (ntck !== 52) begin mismatched++; $display("FAIL t2_tck: got %0d want 52", ntck); end
    compared++;
    if (rdata0 !== 32'hDEADBEEF) begin mismatched++; $display("FAIL t2_rdata: got %h want deadbeef", rdata0); end
    compared++;
    if (lat !== 208) begin mismatched++; $display("FAIL t2_latency: got %0d want 208", lat); end
    compared++;
    if (ir_last !== 9'b1_1111_0011) begin mismatched++; $display("FAIL t2_ir: got %b want 111110011", ir_last); end
    compared++;
    if (hist(52) !== exp_tms(1'b0)) begin mismatched++; $display("FAIL t2_tms: got %h want %h", hist(52), exp_tms(1'b0)); end
  endtask

  task automatic test_start_spam();
    int lat, ntck, nd;
    run_txn(1'b0, 4'h5, 4'hF, 32'h12345678, 1'b1, lat, ntck, nd);
    compared++;
    if (nd !== 1) begin mismatched++; $display("FAIL spam_done_count: got %0d want 1", nd); end
    compared++;
    if (ntck !== 52) begin mismatched++; $display("FAIL spam_tck: got %0d want 52", ntck); end
    compared++;
    if (hist(52) !== exp_tms(1'b0)) begin mismatched++; $display("FAIL spam_tms: got %h want %h", hist(52), exp_tms(1'b0)); end
    compared++;
    if (ir_last !== 9'b1_0101_1111) begin mismatched++; $display("FAIL spam_ir: got %b want 101011111", ir_last); end
    compared++;
    if (dr_last !== 32'h12345678) begin mismatched++; $display("FAIL spam_dr: got %h want 12345678", dr_last); end
    compared++;
    if (busy0 !== 1'b0 || rdata0 !== 32'h0) begin
      mismatched++; $display("FAIL spam_final: busy %b rdata %h want 0/0", busy0, rdata0);
    end
  endtask

  task automatic test_reset_mid();
    int  t0, tck_before, nd = 0, lat, ntck, nd2;
    bit  hit = 1'b0;
    @(negedge iCLK);
    sel = 1'b0; wr_a = 4'h7; rd_a = 4'h5; wdata = 32'hA5A5A5A5; start0 = 1'b1;
    t0 = tck_cnt;
    for (int k = 0; k < 500 && !hit; k++) begin
      @(negedge iCLK);
      start0 = 1'b0;
      if (tck_cnt - t0 == 20) hit = 1'b1;
    end
    compared++;
    if (!hit) begin mismatched++; $display("FAIL mid_reach_tck20: got %0d tck want 20", tck_cnt - t0); end
    iRST = 1'b1;
    @(negedge iCLK);
    compared++;
    if ({tck0, tms0, tdi0, busy0, done0} !== 5'b01000) begin
      mismatched++; $display("FAIL mid_reset_pins: got %b want 01000", {tck0, tms0, tdi0, busy0, done0});
    end
    compared++;
    if (rdata0 !== 32'h0) begin mismatched++; $display("FAIL mid_reset_rdata: got %h want 0", rdata0); end
    iRST = 1'b0;
    tck_before = tck_cnt;
    for (int k = 0; k < 300; k++) begin
      @(negedge iCLK);
      if (done0) nd++;
    end
    compared++;
    if (nd !== 0 || tck_cnt !== tck_before) begin
      mismatched++; $display("FAIL mid_quiet: got done %0d tck %0d want 0/0", nd, tck_cnt - tck_before);
    end
    run_txn(1'b0, 4'hF, 4'h5, 32'h0, 1'b0, lat, ntck, nd2);
    compared++;
    if (ntck !== 58) begin mismatched++; $display("FAIL post_reset_tck: got %0d want 58", ntck); end
    compared++;
    if (hist(58) !== exp_tms(1'b1)) begin mismatched++; $display("FAIL post_reset_tms: got %h want %h", hist(58), exp_tms(1'b1)); end
    compared++;
    if (rdata0 !== 32'h12345678) begin mismatched++; $display("FAIL post_reset_rdata: got %h want 12345678", rdata0); end
    compared++;
    if (lat !== 232) begin mismatched++; $display("FAIL post_reset_latency: got %0d want 232", lat); end
  endtask

  task automatic test_clkdiv1();
    int lat, ntck, nd;
    run_txn(1'b1, 4'h0, 4'hF, 32'h00000001, 1'b0, lat, ntck, nd);
    compared++;
    if (lat !== 116 || ntck !== 58) begin
      mismatched++; $display("FAIL div1_write: got lat %0d tck %0d want 116/58", lat, ntck);
    end
    run_txn(1'b1, 4'hF, 4'h0, 32'hFFFFFFFE, 1'b0, lat, ntck, nd);
    compared++;
    if (rdata1 !== 32'h00000001) begin mismatched++; $display("FAIL div1_rdata: got %h want 00000001", rdata1); end
    compared++;
    if (lat !== 104 || ntck !== 52) begin
      mismatched++; $display("FAIL div1_read: got lat %0d tck %0d want 104/52", lat, ntck);
    end
    compared++;
    if (tgl_bad !== 0 || tgl_n < 100) begin
      mismatched++; $display("FAIL div1_toggle: got bad %0d of %0d want 0 of >=100", tgl_bad, tgl_n);
    end
  endtask

  initial begin
    test_reset();
    test_first_write();
    test_read_back();
    test_start_spam();
    test_reset_mid();
    test_clkdiv1();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
